// File: rtl/student_tlul_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : student_tlul_demux_pkg
//  Description : Address decode and error-response constants for the demux.
//  Revision    : 1.0 - initial release
// ============================================================================
package student_tlul_demux_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;
    localparam int          TGT_MAX_W = 5;

    function automatic int idx_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    // Returns the device index for a mapped address, or num for the error target.
    function automatic logic [TGT_MAX_W-1:0] decode_tgt(
        input logic [31:0] addr,
        input int          num,
        input int          slot_lsb,
        input logic [31:0] base
    );
        int          idx_w;
        logic [31:0] idx;
        logic        in_win;
        idx_w  = idx_width(num);
        idx    = (addr >> slot_lsb) & ((32'd1 << idx_w) - 32'd1);
        in_win = ((addr >> (slot_lsb + idx_w)) == (base >> (slot_lsb + idx_w)));
        if (in_win && (idx < 32'(num))) begin
            return TGT_MAX_W'(idx);
        end
        return TGT_MAX_W'(num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlul_pkg
//  Description : TL-UL channel types and opcodes shared by host and devices.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage
`default_nettype wire

// File: rtl/student_tlul_err_resp.sv
`default_nettype none
// ============================================================================
//  Module      : student_tlul_err_resp
//  Description : Single-entry responder answering unmapped accesses with error.
//  Revision    : 1.0 - initial release
// ============================================================================
module student_tlul_err_resp
    import tlul_pkg::*;
    import student_tlul_demux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  tl_a_op_e   i_a_opcode,
    input  logic [1:0] i_a_size,
    input  logic [7:0] i_a_source,
    input  logic       i_d_ready,
    output logic       o_idle,
    output tl_d2h_t    o_rsp
);

    logic       r_valid;
    logic       r_is_get;
    logic [1:0] r_size;
    logic [7:0] r_source;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_is_get <= 1'b0;
            r_size   <= '0;
            r_source <= '0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_is_get <= (i_a_opcode == Get);
            r_size   <= i_a_size;
            r_source <= i_a_source;
        end else if (r_valid && i_d_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_comb begin
        o_rsp          = '0;
        o_rsp.d_valid  = r_valid;
        o_rsp.d_opcode = r_is_get ? AccessAckData : AccessAck;
        o_rsp.d_data   = r_is_get ? ERR_RDATA : 32'h0;
        o_rsp.d_error  = 1'b1;
        o_rsp.d_size   = r_size;
        o_rsp.d_source = r_source;
    end

    assign o_idle = ~r_valid;

endmodule
`default_nettype wire

// File: rtl/student_tlul_demux_ot.sv
`default_nettype none
// ============================================================================
//  Module      : student_tlul_demux_ot
//  Description : TL-UL 1-to-NUM demux with outstanding-request ordering FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module student_tlul_demux_ot
    import tlul_pkg::*;
    import student_tlul_demux_pkg::*;
#(
    parameter int          NUM       = 2,
    parameter int          SLOT_LSB  = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_OUT   = 4,
    parameter int          ERRCNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  tl_h2d_t             tl_host_i,
    output tl_d2h_t             tl_host_o,
    output tl_h2d_t             tl_device_o [NUM],
    input  tl_d2h_t             tl_device_i [NUM],
    output logic [ERRCNT_W-1:0] err_cnt_o
);

    localparam int IDX_W = idx_width(NUM);
    localparam int TGT_W = IDX_W + 1;
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    localparam logic [TGT_W-1:0] c_err_tgt  = TGT_W'(NUM);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(MAX_OUT - 1);

    logic [TGT_W-1:0]    r_fifo [MAX_OUT];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic [TGT_W-1:0]    r_last_tgt;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic [TGT_W-1:0] w_tgt;
    logic [TGT_W-1:0] w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_route_ok;
    logic             w_tgt_rdy;
    logic             w_accept;
    logic             w_pop;
    logic             w_err_idle;
    tl_d2h_t          w_err_rsp;
    tl_d2h_t          w_rsp;

    assign w_tgt   = TGT_W'(decode_tgt(tl_host_i.a_address, NUM, SLOT_LSB, BASE_ADDR));
    assign w_head  = r_fifo[r_rptr];
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_cnt);

    // Only one target may be in flight at a time, so responses stay in order.
    assign w_route_ok = tl_host_i.a_valid & ~w_full & (w_empty | (w_tgt == r_last_tgt));

    always_comb begin
        w_tgt_rdy = (w_tgt == c_err_tgt) ? w_err_idle : 1'b0;
        for (int k = 0; k < NUM; k++) begin
            if (w_tgt == TGT_W'(k)) begin
                w_tgt_rdy = tl_device_i[k].a_ready;
            end
        end
    end

    assign w_accept = w_route_ok & w_tgt_rdy;

    always_comb begin
        w_rsp = '0;
        if (!w_empty) begin
            if (w_head == c_err_tgt) begin
                w_rsp = w_err_rsp;
            end
            for (int k = 0; k < NUM; k++) begin
                if (w_head == TGT_W'(k)) begin
                    w_rsp = tl_device_i[k];
                end
            end
        end
    end

    always_comb begin
        tl_host_o         = w_rsp;
        tl_host_o.a_ready = w_accept;
    end

    assign w_pop = w_rsp.d_valid & tl_host_i.d_ready;

    generate
        for (genvar k = 0; k < NUM; k++) begin : g_dev
            always_comb begin
                tl_device_o[k]         = tl_host_i;
                tl_device_o[k].a_valid = w_route_ok & (w_tgt == TGT_W'(k));
                tl_device_o[k].d_ready = ~w_empty & (w_head == TGT_W'(k)) & tl_host_i.d_ready;
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_fifo[r_wptr] <= w_tgt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_last_tgt <= c_err_tgt;
            r_err_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_wptr     <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
                r_last_tgt <= w_tgt;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop && (w_head == c_err_tgt) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    student_tlul_err_resp u_err_resp (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_load     (w_accept & (w_tgt == c_err_tgt)),
        .i_a_opcode (tl_host_i.a_opcode),
        .i_a_size   (tl_host_i.a_size),
        .i_a_source (tl_host_i.a_source),
        .i_d_ready  (tl_host_i.d_ready & ~w_empty & (w_head == c_err_tgt)),
        .o_idle     (w_err_idle),
        .o_rsp      (w_err_rsp)
    );

    assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_student_tlul_demux_ot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_student_tlul_demux_ot
//  Description : Scoreboard bench for the TL-UL demux with two RAM devices.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_student_tlul_demux_ot;
    import tlul_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic        err;
        logic [7:0]  src;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    tl_h2d_t     host_i;
    tl_d2h_t     host_o;
    tl_h2d_t     dev_o [2];
    tl_d2h_t     dev_i [2];
    logic [15:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        sbq [$];
    logic [31:0] smem [2][4];
    tl_d2h_t     dq [2][$];
    logic [31:0] dmem [2][4];
    tl_d2h_t     d_new;
    tl_d2h_t     d_nxt;
    exp_t        m_exp;

    always #5 clk = ~clk;

    student_tlul_demux_ot #(
        .NUM       (2),
        .SLOT_LSB  (4),
        .BASE_ADDR (32'h0),
        .MAX_OUT   (4),
        .ERRCNT_W  (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tl_host_i   (host_i),
        .tl_host_o   (host_o),
        .tl_device_o (dev_o),
        .tl_device_i (dev_i),
        .err_cnt_o   (err_cnt)
    );

    // Device model: 4-word RAM per slot, responses queued in arrival order.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                dq[k].delete();
                for (int j = 0; j < 4; j++) dmem[k][j] = 32'h0;
                d_nxt         = '0;
                d_nxt.a_ready = 1'b1;
                dev_i[k]     <= d_nxt;
            end else begin
                if (dev_i[k].d_valid && dev_o[k].d_ready) void'(dq[k].pop_front());
                if (dev_o[k].a_valid && dev_i[k].a_ready) begin
                    d_new          = '0;
                    d_new.d_size   = dev_o[k].a_size;
                    d_new.d_source = dev_o[k].a_source;
                    if (dev_o[k].a_opcode == Get) begin
                        d_new.d_opcode = AccessAckData;
                        d_new.d_data   = dmem[k][dev_o[k].a_address[3:2]];
                    end else begin
                        d_new.d_opcode = AccessAck;
                        dmem[k][dev_o[k].a_address[3:2]] = dev_o[k].a_data;
                    end
                    dq[k].push_back(d_new);
                end
                d_nxt = (dq[k].size() != 0) ? dq[k][0] : '0;
                d_nxt.d_valid = (dq[k].size() != 0);
                d_nxt.a_ready = (dq[k].size() < 6);
                dev_i[k] <= d_nxt;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected response derived from the bench's own decode and shadow memory.
    task automatic push_exp();
        exp_t        e;
        logic [31:0] a;
        logic        mapped;
        int          k;
        a      = host_i.a_address;
        mapped = (a[31:5] == 27'h0);
        k      = int'(a[4]);
        e.src  = host_i.a_source;
        e.err  = ~mapped;
        e.data = 32'h0;
        e.op   = (host_i.a_opcode == Get) ? 3'h1 : 3'h0;
        if (mapped) begin
            if (host_i.a_opcode == Get) e.data = smem[k][a[3:2]];
            else smem[k][a[3:2]] = host_i.a_data;
        end else if (host_i.a_opcode == Get) begin
            e.data = 32'hFFFF_FFFF;
        end
        sbq.push_back(e);
    endtask

    task automatic clear_shadow();
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 4; j++) smem[k][j] = 32'h0;
    endtask

    task automatic drive_a(input tl_a_op_e op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [7:0] src);
        host_i.a_valid   = 1'b1;
        host_i.a_opcode  = op;
        host_i.a_address = addr;
        host_i.a_data    = data;
        host_i.a_source  = src;
        host_i.a_size    = 2'd2;
        host_i.a_mask    = 4'hF;
    endtask

    task automatic wait_accept(input string tag, input int maxcyc);
        bit done = 1'b0;
        for (int i = 0; i < maxcyc && !done; i++) begin
            #1;
            if (host_o.a_ready) begin
                push_exp();
                done = 1'b1;
                @(posedge clk);
                #1 host_i.a_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) host_i.a_valid = 1'b0;
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic issue(input tl_a_op_e op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [7:0] src);
        @(negedge clk);
        drive_a(op, addr, data, src);
        wait_accept("a_accept", 20);
    endtask

    task automatic drain(input int maxcyc);
        for (int i = 0; i < maxcyc && sbq.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sbq.size()), 32'd0);
    endtask

    // Response monitor: samples just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (!rst && host_o.d_valid && host_i.d_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                m_exp = sbq.pop_front();
                check("d_opcode", 32'(host_o.d_opcode), 32'(m_exp.op));
                check("d_data",   host_o.d_data,        m_exp.data);
                check("d_error",  32'(host_o.d_error),  32'(m_exp.err));
                check("d_source", 32'(host_o.d_source), 32'(m_exp.src));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        host_i         = '0;
        host_i.d_ready = 1'b1;
        clear_shadow();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_d_valid", 32'(host_o.d_valid), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        // Writes then read-back across both device slots
        issue(PutFullData, 32'h04, 32'h1, 8'h1);
        issue(PutFullData, 32'h14, 32'h2, 8'h2);
        issue(PutFullData, 32'h00, 32'h2, 8'h3);
        issue(Get, 32'h04, 32'h0, 8'h4);
        issue(Get, 32'h14, 32'h0, 8'h5);
        issue(Get, 32'h00, 32'h0, 8'h6);
        issue(Get, 32'h18, 32'h0, 8'h7);
        drain(50);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);

        // Unmapped accesses
        issue(Get, 32'h20, 32'h0, 8'h25);
        drain(50);
        check("t2_err_cnt_get", 32'(err_cnt), 32'd1);
        issue(PutFullData, 32'h1000, 32'h1234, 8'h26);
        drain(50);
        check("t2_err_cnt_put", 32'(err_cnt), 32'd2);

        // Full FIFO blocks the fifth request until a response drains
        @(negedge clk);
        host_i.d_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(Get, 32'(i * 4), 32'h0, 8'(8'h40 + i));
        @(negedge clk);
        drive_a(Get, 32'h08, 32'h0, 8'h44);
        repeat (3) @(negedge clk);
        #1 check("t3_full_stall", 32'(host_o.a_ready), 32'd0);
        host_i.d_ready = 1'b1;
        wait_accept("t3_fifth_accept", 20);
        drain(50);

        // Different target stalls while another is outstanding
        @(negedge clk);
        host_i.d_ready = 1'b0;
        issue(Get, 32'h04, 32'h0, 8'h50);
        @(negedge clk);
        drive_a(Get, 32'h14, 32'h0, 8'h51);
        repeat (2) @(negedge clk);
        #1 check("t4_tgt_stall", 32'(host_o.a_ready), 32'd0);
        host_i.d_ready = 1'b1;
        wait_accept("t4_second_accept", 20);
        drain(50);

        // Mapped / unmapped / mapped in issue order
        issue(PutFullData, 32'h18, 32'hCAFE_F00D, 8'h60);
        issue(Get, 32'h40, 32'h0, 8'h61);
        issue(Get, 32'h18, 32'h0, 8'h62);
        drain(50);
        check("t5_err_cnt", 32'(err_cnt), 32'd3);

        // Reset with requests outstanding
        @(negedge clk);
        host_i.d_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(Get, 32'h14, 32'h0, 8'(8'h70 + i));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        clear_shadow();
        #1;
        check("t6_d_valid", 32'(host_o.d_valid), 32'd0);
        check("t6_err_cnt", 32'(err_cnt), 32'd0);
        host_i.d_ready = 1'b1;
        issue(PutFullData, 32'h04, 32'hA5A5_0001, 8'h80);
        issue(Get, 32'h04, 32'h0, 8'h81);
        drain(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
